// File: rtl/hls_kernel_launcher.sv
// hls_kernel_launcher
//   Sequencer for the AXI-lite control slave of an HLS kernel. It accepts one
//   job descriptor, programs the argument registers, enables the done
//   interrupt (IER, GIE) and sets ap_start. It then waits for the kernel
//   interrupt, clears the ISR and reads AP_CTRL back before it reports a
//   completion status.
//
//   Optional feature: define HLS_KERNEL_LAUNCHER_TIMEOUT_EN to add a watchdog
//   on the interrupt wait. When the watchdog expires the launcher ends the job
//   with status 2'b10 and skips the ISR write and the AP_CTRL read.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   job_valid_i/_ready_o, job_args_i
//                       job descriptor handshake; word i at [32i+31:32i]
//   done_valid_o/_ready_i, done_status_o
//                       completion handshake; 00 OK, 01 bus error, 10 timeout
//   busy_o              a job is in flight
//   interrupt_i         kernel level interrupt
//   m_aw*/m_w*/m_b*     AXI-lite write channels (master side)
//   m_ar*/m_r*          AXI-lite read channels (master side)
module hls_kernel_launcher #(
  parameter int NUM_ARGS       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int ARG_BASE       = 32'h10,
  parameter int ARG_STRIDE     = 32'h8,
  parameter int TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [32*NUM_ARGS-1:0]   job_args_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic [1:0]               done_status_o,
  output logic                     busy_o,
  input  logic                     interrupt_i,
  output logic                     m_awvalid_o,
  input  logic                     m_awready_i,
  output logic [ADDR_WIDTH-1:0]    m_awaddr_o,
  output logic                     m_wvalid_o,
  input  logic                     m_wready_i,
  output logic [31:0]              m_wdata_o,
  output logic [3:0]               m_wstrb_o,
  input  logic                     m_bvalid_i,
  output logic                     m_bready_o,
  input  logic [1:0]               m_bresp_i,
  output logic                     m_arvalid_o,
  input  logic                     m_arready_i,
  output logic [ADDR_WIDTH-1:0]    m_araddr_o,
  input  logic                     m_rvalid_i,
  output logic                     m_rready_o,
  input  logic [31:0]              m_rdata_i,
  input  logic [1:0]               m_rresp_i
);

  localparam int IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_AP_CTRL = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_GIE     = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IER     = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ISR     = ADDR_WIDTH'(32'h0C);

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_BUS_ERR = 2'b01;
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ARG, S_WR_IER, S_WR_GIE, S_WR_START,
    S_WAIT_IRQ, S_WR_ISR, S_RD_CTRL, S_DONE
  } state_e;

  // SETUP loads the channel registers, ADDR waits for AW/W (or AR), RESP for B (or R)
  typedef enum logic [1:0] { PH_SETUP, PH_ADDR, PH_RESP } phase_e;

  state_e                    state_q, state_d;
  phase_e                    phase_q, phase_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [32*NUM_ARGS-1:0]    args_q, args_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic                      done_valid_q, done_valid_d;
  logic [1:0]                status_q, status_d;
  logic                      job_ready_q, job_ready_d;
  logic                      busy_q, busy_d;
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
  logic [31:0]               cnt_q, cnt_d;
`endif

  logic [31:0]               arg_words_s [NUM_ARGS];
  logic [ADDR_WIDTH-1:0]     wr_addr_s;
  logic [31:0]               wr_data_s;
  state_e                    wr_next_s;
  logic [IDX_W-1:0]          idx_next_s;

  // ap_done in the AP_CTRL read data is clear-on-read and only informational
  logic unused_s;
  assign unused_s = &{1'b0, m_rdata_i, TIMEOUT_CYCLES[0]};

  // Split the latched descriptor into argument words
  always_comb begin
    for (int k = 0; k < NUM_ARGS; k++) begin
      arg_words_s[k] = args_q[32*k +: 32];
    end
  end

  // Target, payload and follow-on state of the write owned by the current state
  always_comb begin
    wr_addr_s  = '0;
    wr_data_s  = 32'h0000_0001;
    wr_next_s  = S_IDLE;
    idx_next_s = idx_q;
    case (state_q)
      S_WR_ARG: begin
        wr_addr_s = ADDR_WIDTH'(ARG_BASE) + ADDR_WIDTH'(ARG_STRIDE) * ADDR_WIDTH'(idx_q);
        wr_data_s = arg_words_s[idx_q];
        if (idx_q == LAST_IDX) begin
          wr_next_s  = S_WR_IER;
          idx_next_s = '0;
        end else begin
          wr_next_s  = S_WR_ARG;
          idx_next_s = idx_q + IDX_W'(1);
        end
      end
      S_WR_IER: begin
        wr_addr_s = ADDR_IER;
        wr_next_s = S_WR_GIE;
      end
      S_WR_GIE: begin
        wr_addr_s = ADDR_GIE;
        wr_next_s = S_WR_START;
      end
      S_WR_START: begin
        wr_addr_s = ADDR_AP_CTRL;
        wr_next_s = S_WAIT_IRQ;
      end
      S_WR_ISR: begin
        wr_addr_s = ADDR_ISR;
        wr_next_s = S_RD_CTRL;
      end
      default: begin
        wr_addr_s = '0;
        wr_next_s = S_IDLE;
      end
    endcase
  end

  // Next-state and next-output logic of the launch sequencer
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    args_d     = args_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    status_d   = status_q;
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
    // Held at zero outside WAIT_IRQ, so it starts from zero on every entry
    cnt_d      = 32'd0;
`endif

    case (state_q)
      S_IDLE: begin
        if (job_valid_i && job_ready_q) begin
          args_d   = job_args_i;
          idx_d    = '0;
          status_d = STAT_OK;
          phase_d  = PH_SETUP;
          state_d  = S_WR_ARG;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_WR_ARG, S_WR_IER, S_WR_GIE, S_WR_START, S_WR_ISR: begin
        case (phase_q)
          PH_SETUP: begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = wr_addr_s;
            wdata_d   = wr_data_s;
            phase_d   = PH_ADDR;
          end
          PH_ADDR: begin
            // AW and W retire independently; B is accepted once both are gone
            if (awvalid_q && m_awready_i) begin
              awvalid_d = 1'b0;
            end else begin
              awvalid_d = awvalid_q;
            end
            if (wvalid_q && m_wready_i) begin
              wvalid_d = 1'b0;
            end else begin
              wvalid_d = wvalid_q;
            end
            if (!awvalid_d && !wvalid_d) begin
              bready_d = 1'b1;
              phase_d  = PH_RESP;
            end else begin
              phase_d  = PH_ADDR;
            end
          end
          PH_RESP: begin
            if (m_bvalid_i) begin
              bready_d = 1'b0;
              phase_d  = PH_SETUP;
              if (m_bresp_i != 2'b00) begin
                status_d = STAT_BUS_ERR;
                state_d  = S_DONE;
              end else begin
                idx_d    = idx_next_s;
                state_d  = wr_next_s;
              end
            end else begin
              bready_d = 1'b1;
            end
          end
          default: begin
            phase_d = PH_SETUP;
          end
        endcase
      end

      S_WAIT_IRQ: begin
        if (interrupt_i) begin
          phase_d = PH_SETUP;
          state_d = S_WR_ISR;
        end else begin
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
          if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            status_d = STAT_TIMEOUT;
            state_d  = S_DONE;
          end else begin
            cnt_d    = cnt_q + 32'd1;
            state_d  = S_WAIT_IRQ;
          end
`else
          state_d = S_WAIT_IRQ;
`endif
        end
      end

      S_RD_CTRL: begin
        case (phase_q)
          PH_SETUP: begin
            arvalid_d = 1'b1;
            araddr_d  = ADDR_AP_CTRL;
            phase_d   = PH_ADDR;
          end
          PH_ADDR: begin
            if (m_arready_i) begin
              arvalid_d = 1'b0;
              rready_d  = 1'b1;
              phase_d   = PH_RESP;
            end else begin
              arvalid_d = 1'b1;
            end
          end
          PH_RESP: begin
            if (m_rvalid_i) begin
              rready_d = 1'b0;
              phase_d  = PH_SETUP;
              status_d = (m_rresp_i != 2'b00) ? STAT_BUS_ERR : STAT_OK;
              state_d  = S_DONE;
            end else begin
              rready_d = 1'b1;
            end
          end
          default: begin
            phase_d = PH_SETUP;
          end
        endcase
      end

      S_DONE: begin
        if (done_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        phase_d = PH_SETUP;
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs follow the state being entered, so they are registered
    job_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any job at once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_SETUP;
      idx_q        <= '0;
      args_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= 32'h0;
      araddr_q     <= '0;
      done_valid_q <= 1'b0;
      status_q     <= STAT_OK;
      job_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
      cnt_q        <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      args_q       <= args_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      done_valid_q <= done_valid_d;
      status_q     <= status_d;
      job_ready_q  <= job_ready_d;
      busy_q       <= busy_d;
`ifdef HLS_KERNEL_LAUNCHER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign job_ready_o   = job_ready_q;
  assign busy_o        = busy_q;
  assign done_valid_o  = done_valid_q;
  assign done_status_o = status_q;
  assign m_awvalid_o   = awvalid_q;
  assign m_awaddr_o    = awaddr_q;
  assign m_wvalid_o    = wvalid_q;
  assign m_wdata_o     = wdata_q;
  assign m_wstrb_o     = 4'hF;
  assign m_bready_o    = bready_q;
  assign m_arvalid_o   = arvalid_q;
  assign m_araddr_o    = araddr_q;
  assign m_rready_o    = rready_q;

endmodule
